rv32i_mc_control_unit: RTL and testbench

Multi-cycle control unit for the RV32I core. It replaces the single-cycle decoder with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles through a shared ALU and a unified memory port. It extends the decoded set to the full branch family, jalr, lui and the shift/xor/sltu ALU ops. It sits between the instruction register and the multi-cycle datapath muxes.

---
 rtl/rv32i_mc_control_unit.sv | 213 +++++++++++++++++++++
 tb/tb_rv32i_mc_control_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mc_control_unit.sv
// rtl/rv32i_mc_control_unit.sv - multi-cycle RV32I control FSM (Moore, shared ALU, unified memory port)
// Define RV32I_MC_MEM_WAIT_EN to add mem_ready and stall FETCH/MEMREAD/MEMWRITE until it is high.
module rv32i_mc_control_unit #(
  parameter int ALUCTRL_W       = 4,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 LT,
  input  logic                 LTU,
`ifdef RV32I_MC_MEM_WAIT_EN
  input  logic                 mem_ready,
`endif
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 illegal,
  output logic [3:0]           state_o
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
    S_LINK = 4'd12, S_LUI = 4'd13, S_TRAP = 4'd14
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9;

  state_t     state_q, state_d;
  logic       mem_rdy;
  logic       pc_w, mem_w, ir_w, reg_w, adr_src, taken;
  logic [1:0] res_src, src_a, src_b;
  logic [3:0] alu_op, alu_dec;

`ifdef RV32I_MC_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = LT;
      3'b101:  taken = !LT;
      3'b110:  taken = LTU;
      3'b111:  taken = !LTU;
      default: taken = 1'b0;
    endcase
  end

  // sub is only meaningful for register-register ops; addi ignores instr[30]
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_w    = 1'b0;
    mem_w   = 1'b0;
    ir_w    = 1'b0;
    reg_w   = 1'b0;
    adr_src = 1'b0;
    res_src = 2'b00;
    src_a   = 2'b00;
    src_b   = 2'b00;
    alu_op  = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_w    = mem_rdy;
        pc_w    = mem_rdy;
        src_b   = 2'b10;
        res_src = 2'b10;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JAL;
          7'b1100111:             state_d = S_JALR;
          7'b0110111:             state_d = S_LUI;
          default:                state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        res_src = 2'b01;
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_EXECR: begin
        src_a   = 2'b10;
        alu_op  = alu_dec;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_op  = alu_dec;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        src_a   = 2'b10;
        alu_op  = ALU_SUB;
        pc_w    = taken;
        state_d = S_FETCH;
      end
      S_JAL: begin
        pc_w    = 1'b1;
        src_a   = 2'b01;
        src_b   = 2'b10;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        res_src = 2'b10;
        pc_w    = 1'b1;
        state_d = S_LINK;
      end
      S_LINK: begin
        src_a   = 2'b01;
        src_b   = 2'b10;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        src_a   = 2'b11;
        src_b   = 2'b01;
        state_d = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: ImmSrc = 3'b000;
      7'b0100011:                         ImmSrc = 3'b001;
      7'b1100011:                         ImmSrc = 3'b010;
      7'b1101111:                         ImmSrc = 3'b011;
      7'b0110111:                         ImmSrc = 3'b100;
      default:                            ImmSrc = 3'b000;
    endcase
  end

  // strobes are gated by rst_n so nothing leaks out while FETCH is held in reset
  assign PCWrite    = rst_n & pc_w;
  assign MemWrite   = rst_n & mem_w;
  assign IRWrite    = rst_n & ir_w;
  assign RegWrite   = rst_n & reg_w;
  assign illegal    = rst_n & (state_q == S_TRAP);
  assign AdrSrc     = adr_src;
  assign ResultSrc  = res_src;
  assign ALUSrcA    = src_a;
  assign ALUSrcB    = src_b;
  assign ALUControl = ALUCTRL_W'(alu_op);
  assign state_o    = state_q;

endmodule

// File: tb/tb_rv32i_mc_control_unit.sv
// tb/tb_rv32i_mc_control_unit.sv - randomized instruction-level check of rv32i_mc_control_unit
module tb_rv32i_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, LT, LTU;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl, state_o;

  rv32i_mc_control_unit #(.ALUCTRL_W(4), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .LT(LT), .LTU(LTU),
`ifdef RV32I_MC_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // one expected cycle; -1 in a mux field means the value is not specified there
  typedef struct {
    int st, pcw, mw, irw, rw, adr, rs, sa, sb, alu;
  } exp_t;
  exp_t q[$];

  function automatic void push(input int st, input int pcw, input int mw, input int irw,
                               input int rw, input int adr, input int rs, input int sa,
                               input int sb, input int alu);
    exp_t e;
    e.st = st; e.pcw = pcw; e.mw = mw; e.irw = irw; e.rw = rw;
    e.adr = adr; e.rs = rs; e.sa = sa; e.sb = sb; e.alu = alu;
    q.push_back(e);
  endfunction

  function automatic int ref_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (o[5] && f7) ? 1 : 0;
      3'd1: return 7;
      3'd2: return 5;
      3'd3: return 6;
      3'd4: return 4;
      3'd5: return f7 ? 9 : 8;
      3'd6: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int ref_taken(input logic [2:0] f3, input logic z, input logic lt,
                                   input logic ltu);
    case (f3)
      3'd0: return int'(z);
      3'd1: return int'(!z);
      3'd4: return int'(lt);
      3'd5: return int'(!lt);
      3'd6: return int'(ltu);
      3'd7: return int'(!ltu);
      default: return 0;
    endcase
  endfunction

  function automatic int ref_imm(input logic [6:0] o);
    case (o)
      7'b0000011, 7'b0010011, 7'b1100111: return 0;
      7'b0100011: return 1;
      7'b1100011: return 2;
      7'b1101111: return 3;
      7'b0110111: return 4;
      default:    return 0;
    endcase
  endfunction

  // called just after a falling edge with the FSM in FETCH; returns likewise
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input logic lt, input logic ltu);
    int n;
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; LT = lt; LTU = ltu;
    q.delete();
    push(0, 1, 0, 1, 0, 0, 2, 0, 2, 0);
    push(1, 0, 0, 0, 0, -1, -1, 1, 1, 0);
    case (o)
      7'b0000011: begin
        push(2, 0, 0, 0, 0, -1, -1, 2, 1, 0);
        push(3, 0, 0, 0, 0, 1, -1, -1, -1, -1);
        push(4, 0, 0, 0, 1, -1, 1, -1, -1, -1);
      end
      7'b0100011: begin
        push(2, 0, 0, 0, 0, -1, -1, 2, 1, 0);
        push(5, 0, 1, 0, 0, 1, -1, -1, -1, -1);
      end
      7'b0110011: begin
        push(6, 0, 0, 0, 0, -1, -1, 2, 0, ref_alu(o, f3, f7));
        push(8, 0, 0, 0, 1, -1, 0, -1, -1, -1);
      end
      7'b0010011: begin
        push(7, 0, 0, 0, 0, -1, -1, 2, 1, ref_alu(o, f3, f7));
        push(8, 0, 0, 0, 1, -1, 0, -1, -1, -1);
      end
      7'b1100011: push(9, ref_taken(f3, z, lt, ltu), 0, 0, 0, -1, 0, 2, 0, 1);
      7'b1101111: begin
        push(10, 1, 0, 0, 0, -1, 0, 1, 2, 0);
        push(8, 0, 0, 0, 1, -1, 0, -1, -1, -1);
      end
      7'b1100111: begin
        push(11, 1, 0, 0, 0, -1, 2, 2, 1, 0);
        push(12, 0, 0, 0, 0, -1, -1, 1, 2, 0);
        push(8, 0, 0, 0, 1, -1, 0, -1, -1, -1);
      end
      default: begin
        push(13, 0, 0, 0, 0, -1, -1, 3, 1, 0);
        push(8, 0, 0, 0, 1, -1, 0, -1, -1, -1);
      end
    endcase
    #1;
    n = 0;
    foreach (q[i]) begin
      check({name, ".state"}, int'(state_o), q[i].st);
      check({name, ".PCWrite"}, int'(PCWrite), q[i].pcw);
      check({name, ".MemWrite"}, int'(MemWrite), q[i].mw);
      check({name, ".IRWrite"}, int'(IRWrite), q[i].irw);
      check({name, ".RegWrite"}, int'(RegWrite), q[i].rw);
      check({name, ".illegal"}, int'(illegal), 0);
      check({name, ".ImmSrc"}, int'(ImmSrc), ref_imm(o));
      if (q[i].adr >= 0) check({name, ".AdrSrc"}, int'(AdrSrc), q[i].adr);
      if (q[i].rs  >= 0) check({name, ".ResultSrc"}, int'(ResultSrc), q[i].rs);
      if (q[i].sa  >= 0) check({name, ".ALUSrcA"}, int'(ALUSrcA), q[i].sa);
      if (q[i].sb  >= 0) check({name, ".ALUSrcB"}, int'(ALUSrcB), q[i].sb);
      if (q[i].alu >= 0) check({name, ".ALUControl"}, int'(ALUControl), q[i].alu);
      @(negedge clk); #1;
      n++;
    end
    check({name, ".cycles"}, n, q.size());
    check({name, ".back_to_fetch"}, int'(state_o), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset.state", int'(state_o), 0);
    check("reset.PCWrite", int'(PCWrite), 0);
    check("reset.IRWrite", int'(IRWrite), 0);
    check("reset.MemWrite", int'(MemWrite), 0);
    check("reset.RegWrite", int'(RegWrite), 0);
    check("reset.illegal", int'(illegal), 0);
    check("reset.ALUSrcB", int'(ALUSrcB), 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [6:0] ops [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                          7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

  initial begin
    op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0;
    Zero = 1'b0; LT = 1'b0; LTU = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    do_reset();

    run_instr("add",  7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr("sub",  7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr("srai", 7'b0010011, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr("srli", 7'b0010011, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr("lw",   7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr("sw",   7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr("bne_z1", 7'b1100011, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_instr("bne_z0", 7'b1100011, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr("bltu",   7'b1100011, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    run_instr("jalr", 7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr("jal",  7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr("lui",  7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 120; i++) begin
      run_instr("rand", ops[$urandom_range(0, 7)], 3'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom));
    end

    // reset pulse while the store strobe is active
    op = 7'b0100011; funct3 = 3'd2;
    repeat (3) @(negedge clk);
    #1;
    check("rstmid.state_before", int'(state_o), 5);
    check("rstmid.MemWrite_before", int'(MemWrite), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid.MemWrite", int'(MemWrite), 0);
    check("rstmid.state", int'(state_o), 0);
    check("rstmid.RegWrite", int'(RegWrite), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_instr("post_rst_add", 7'b0110011, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef RV32I_MC_MEM_WAIT_EN
    op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("wait.state", int'(state_o), 0);
      check("wait.IRWrite", int'(IRWrite), 0);
      check("wait.PCWrite", int'(PCWrite), 0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    check("wait.IRWrite_ready", int'(IRWrite), 1);
    check("wait.PCWrite_ready", int'(PCWrite), 1);
    @(negedge clk); #1;
    check("wait.decode", int'(state_o), 1);
    repeat (3) @(negedge clk);
    #1;
    check("wait.back_to_fetch", int'(state_o), 0);
`endif

    // unknown opcode parks in TRAP until reset
    op = 7'b1111111;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("trap.state", int'(state_o), 14);
      check("trap.illegal", int'(illegal), 1);
      check("trap.PCWrite", int'(PCWrite), 0);
      @(negedge clk);
    end
    do_reset();
    #1;
    check("trap.exit_state", int'(state_o), 0);
    check("trap.exit_illegal", int'(illegal), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
